mux_pipe_n: RTL
===============

Name: mux_pipe_n

Overview:
Parametrised N-way, W-bit select/merge stage with a valid/ready handshake and a registered output. It is the pipelined successor to the processor's fixed-width 2/3/4-input muxes and is used for writeback and operand selection once the datapath is pipelined. An unused select code drives a defined DEFAULT value, never a latch. A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
N, 3, number of data inputs (>=2)
W, 32, data width in bits
SEL_W, $clog2(N) (min 1), select width
DEFAULT, 0, W-bit value output when sel >= N

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream presents sel/data_in
in_ready  out  1  stage can accept; registered
sel  in  SEL_W  input index
data_in  in  N*W  flattened inputs; input k occupies bits [k*W +: W]
out_valid  out  1  out_data/out_sel hold a result
out_ready  in  1  downstream accepts
out_data  out  W  selected word
out_sel  out  SEL_W  sel that produced out_data
sel_err  out  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Reset values (async, immediate): in_ready=1, out_valid=0, out_data=0, out_sel=0, sel_err=0, state=EMPTY, skid register cleared.
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- Selection: word = (sel < N) ? data_in[sel*W +: W] : DEFAULT. The word is computed combinationally and captured at accept. Latency is 1 cycle from accept to out_valid.
- Storage: main register (drives outputs) plus one skid register.
- State EMPTY: on accept, load main and go to ONE.
- State ONE:
  - accept and emit together: reload main, stay in ONE.
  - accept only: load skid, go to TWO.
  - emit only: go to EMPTY.
- State TWO: in_ready=0. On emit, move skid into main and go to ONE. No accept is possible in TWO.
- in_ready is registered: it is 0 exactly when next state is TWO.
- Throughput: 1 result per cycle while out_ready=1.
- out_data and out_sel stay stable while out_valid=1 and out_ready=0.
- Inputs are ignored when in_ready=0. Upstream must hold its values until accept.
- rst asserted mid-transfer drops all buffered data. There is no partial output.

Optional Feature:
MUX_SEL_CHECK_EN
- Defined: an accept with sel >= N sets sel_err, which holds until rst. out_data=DEFAULT for that item.
- Undefined: sel_err is tied to 0. Out-of-range sel still yields DEFAULT.

Decomposition:
- Package mux_pkg holds the state enum (EMPTY, ONE, TWO), the SEL_W computation function, and the DEFAULT constant.
- Sub-module mux_skid_buf (W+SEL_W payload, valid/ready, 2 entries) holds the handshake FSM. mux_pipe_n adds the selection logic and the error flag around it.

Test Plan:
1. N=3, W=32, out_ready=1. Issue sel=0,1,2 on consecutive cycles with data_in words 0x11111111/0x22222222/0x33333333. Expect out_data 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, each one cycle after its accept, with in_ready held at 1.
2. sel=3 with N=3 and DEFAULT=0xDEADBEEF. Expect out_data=0xDEADBEEF and out_sel=3. With MUX_SEL_CHECK_EN, sel_err=1 from the next cycle and still 1 after 10 more valid transfers.
3. Backpressure: out_ready=0, stream items A, B, C. Expect A accepted and B accepted into skid, then in_ready=0 on the cycle after B's accept. C is held by upstream. Raising out_ready produces A, B, C in order with no loss or duplication.
4. Random in_valid/out_ready (50% each) over 10k items. Scoreboard order and values; expect zero mismatches. out_data must never change while out_valid=1 and out_ready=0.
5. Assert rst while in state TWO. Expect out_valid=0, in_ready=1, and sel_err=0 immediately, before the next clk edge. The first item after release emerges normally.
6. N=2, W=8, SEL_W=1: basic pass-through with sel=1 and data_in=0xA55A. Expect out_data=0xA5.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and constants for the pipelined N-way select stage.
package mux_pkg;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } mux_state_t;

  // Value driven for select codes with no matching input.
  localparam logic [31:0] MUX_DEFAULT = 32'h0;

  // Select width for an N-input mux. It is never narrower than one bit.
  function automatic int mux_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry valid/ready buffer with a registered in_ready.
// The main register drives the outputs. The skid register absorbs the one
// item that arrives on the cycle the downstream stalls.
module mux_skid_buf
  import mux_pkg::*;
#(
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [P-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_data
);

  mux_state_t   r_state;
  mux_state_t   w_nxt;
  logic [P-1:0] r_main;
  logic [P-1:0] r_skid;
  logic         r_in_ready;
  logic         w_acc;
  logic         w_emit;
  logic         w_ld_main;
  logic         w_ld_skid;
  logic         w_mv_skid;

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;
  assign w_acc     = in_valid & r_in_ready;
  assign w_emit    = out_valid & out_ready;

  // Next occupancy and the register-load strobes.
  always_comb begin
    w_nxt     = r_state;
    w_ld_main = 1'b0;
    w_ld_skid = 1'b0;
    w_mv_skid = 1'b0;
    case (r_state)
      EMPTY: if (w_acc) begin
        w_nxt     = ONE;
        w_ld_main = 1'b1;
      end
      ONE: begin
        if (w_acc && w_emit) begin
          w_ld_main = 1'b1;
        end else if (w_acc) begin
          w_ld_skid = 1'b1;
          w_nxt     = TWO;
        end else if (w_emit) begin
          w_nxt = EMPTY;
        end
      end
      TWO: if (w_emit) begin
        w_mv_skid = 1'b1;
        w_nxt     = ONE;
      end
      default: w_nxt = EMPTY;
    endcase
  end

  // State, storage, and the registered in_ready. It drops only when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_nxt;
      r_in_ready <= (w_nxt != TWO);
      if (w_ld_main)      r_main <= in_data;
      else if (w_mv_skid) r_main <= r_skid;
      if (w_ld_skid)      r_skid <= in_data;
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// N-way, W-bit select stage with a registered valid/ready output.
// An out-of-range select yields DEFAULT.
// Optional macro MUX_SEL_CHECK_EN: when it is defined, a sticky sel_err flag
// records any accept with an out-of-range select.
module mux_pipe_n
  import mux_pkg::*;
#(
  parameter int             N       = 3,
  parameter int             W       = 32,
  parameter int             SEL_W   = mux_sel_w(N),
  parameter logic [W-1:0]   DEFAULT = W'(MUX_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             sel_err
);

  logic [W-1:0] w_word;

  // Pick the selected word. A code with no matching input keeps DEFAULT.
  always_comb begin
    w_word = DEFAULT;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) w_word = data_in[k*W +: W];
    end
  end

  mux_skid_buf #(.P(W + SEL_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({sel, w_word}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_sel, out_data})
  );

`ifdef MUX_SEL_CHECK_EN
  localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);
  logic w_bad_acc;
  logic r_sel_err;

  assign w_bad_acc = in_valid & in_ready & ({1'b0, sel} >= N_EXT);
  assign sel_err   = r_sel_err;

  // Sticky flag. Only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_sel_err <= 1'b0;
    else if (w_bad_acc) r_sel_err <= 1'b1;
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule
